// File: rtl/booth_pkg.sv
// Shared definitions for the radix-2 Booth multiplier controller:
// FSM state encoding, mult_control bit positions and {Q0, Q-1} pair codes.
package booth_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        ITER   = 3'd3,
        SHIFT  = 3'd4,
        DONE   = 3'd5
    } state_t;

    // mult_control = {load_A, load_B, load_add, shift_HQ_LQ_Q_1, add_sub}
    localparam int MC_LOAD_A   = 4;
    localparam int MC_LOAD_B   = 3;
    localparam int MC_LOAD_ADD = 2;
    localparam int MC_SHIFT    = 1;
    localparam int MC_ADD_SUB  = 0;

    localparam logic [1:0] NOP0 = 2'b00;
    localparam logic [1:0] ADD  = 2'b01;
    localparam logic [1:0] SUB  = 2'b10;
    localparam logic [1:0] NOP1 = 2'b11;

endpackage

// File: rtl/booth_ctrl.sv
// Booth multiplier sequencer: loads operands, then walks N iterations,
// inserting an add/sub cycle ahead of the shift whenever {Q0, Q-1} differ.
module booth_ctrl
    import booth_pkg::*;
#(
    parameter int N = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] Q_LSB,
    output logic [4:0] mult_control,
    output logic       busy,
    output logic       done
);

    localparam int             CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]  LAST = CW'(N - 1);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          last_iter;
    logic          cnt_clr;
    logic          cnt_inc;
    logic          is_op;

    assign last_iter = (cnt == LAST);
    assign is_op     = (Q_LSB == ADD) || (Q_LSB == SUB);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = LOAD_A;
            LOAD_A:  state_nxt = LOAD_B;
            LOAD_B:  state_nxt = ITER;
            ITER:    if (is_op)          state_nxt = SHIFT;
                     else if (last_iter) state_nxt = DONE;
            SHIFT:   state_nxt = last_iter ? DONE : ITER;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mult_control = '0;
        busy         = (state != IDLE);
        done         = (state == DONE);
        cnt_clr      = 1'b0;
        cnt_inc      = 1'b0;
        unique case (state)
            LOAD_A: mult_control[MC_LOAD_A] = 1'b1;
            LOAD_B: begin
                mult_control[MC_LOAD_B] = 1'b1;
                cnt_clr                 = 1'b1;
            end
            ITER: begin
                if (is_op) begin
                    mult_control[MC_LOAD_ADD] = 1'b1;
                    mult_control[MC_ADD_SUB]  = (Q_LSB == ADD);
                end else begin
                    mult_control[MC_SHIFT] = 1'b1;
                    cnt_inc                = 1'b1;
                end
            end
            SHIFT: begin
                mult_control[MC_SHIFT] = 1'b1;
                cnt_inc                = 1'b1;
            end
            default: ;
        endcase
    end

    // The final shift leaves the counter at N-1 rather than wrapping to 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                       cnt <= '0;
        else if (cnt_clr)               cnt <= '0;
        else if (cnt_inc && !last_iter) cnt <= cnt + CW'(1);
    end

endmodule

// File: tb/tb_booth_ctrl.sv
// Bench for booth_ctrl paired with a behavioural shift-add Booth datapath;
// latency, pulse counts and product are predicted from the operands alone.
module tb_booth_ctrl;

    localparam int N = 8;

    logic                clk;
    logic                rst;
    logic                start;
    logic [1:0]          q_lsb;
    logic [4:0]          mc;
    logic                busy;
    logic                done;

    logic signed [N-1:0] a_in, b_in;
    logic signed [N-1:0] m_reg, h_reg;
    logic        [N-1:0] q_reg;
    logic                q1_reg;
    logic signed [2*N-1:0] y;

    int errors = 0;
    int checks = 0;

    booth_ctrl #(.N(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .Q_LSB        (q_lsb),
        .mult_control (mc),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath: M multiplicand, {H,Q,Q-1} accumulator/multiplier chain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_reg  <= '0;
            h_reg  <= '0;
            q_reg  <= '0;
            q1_reg <= 1'b0;
        end else begin
            if (mc[4]) m_reg <= a_in;
            if (mc[3]) begin
                q_reg  <= b_in;
                h_reg  <= '0;
                q1_reg <= 1'b0;
            end
            if (mc[2]) h_reg <= mc[0] ? h_reg + m_reg : h_reg - m_reg;
            if (mc[1]) {h_reg, q_reg, q1_reg} <= {h_reg[N-1], h_reg, q_reg};
        end
    end

    assign q_lsb = {q_reg[0], q1_reg};
    assign y     = {h_reg, q_reg};

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Add/sub count: bit transitions scanning b from LSB with an implicit 0 below.
    function automatic int booth_k(input logic [N-1:0] b);
        int  k = 0;
        logic prev = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (b[i] != prev) k++;
            prev = b[i];
        end
        return k;
    endfunction

    // Caller is at the falling edge of the cycle in which start is sampled.
    task automatic run_op(input logic signed [N-1:0] a, input logic signed [N-1:0] b,
                          input bit hold, input string tag);
        int k, cyc, n_la, n_lb, n_add, n_sh, done_cyc;
        bit bad_busy, bad_excl;
        k = booth_k(b);
        a_in = a; b_in = b; start = 1'b1;
        cyc = 0; n_la = 0; n_lb = 0; n_add = 0; n_sh = 0; done_cyc = -1;
        bad_busy = 0; bad_excl = 0;
        while (done_cyc < 0 && cyc < 2*N + 10) begin
            @(negedge clk);
            cyc++;
            if (!hold && cyc == 1) start = 1'b0;
            if (!busy) bad_busy = 1;
            if (int'(mc[4]) + int'(mc[3]) + int'(mc[2]) + int'(mc[1]) > 1) bad_excl = 1;
            if (!mc[2] && mc[0]) bad_excl = 1;
            n_la  += int'(mc[4]);
            n_lb  += int'(mc[3]);
            n_add += int'(mc[2]);
            n_sh  += int'(mc[1]);
            if (done) begin
                done_cyc = cyc;
                chk({tag, " product"}, longint'(y), longint'(a) * longint'(b));
            end
        end
        chk({tag, " done cycle"}, done_cyc, 3 + N + k);
        chk({tag, " load_A pulses"}, n_la, 1);
        chk({tag, " load_B pulses"}, n_lb, 1);
        chk({tag, " load_add pulses"}, n_add, k);
        chk({tag, " shift pulses"}, n_sh, N);
        chk({tag, " busy gap"}, bad_busy, 0);
        chk({tag, " control exclusivity"}, bad_excl, 0);
    endtask

    initial begin
        logic signed [N-1:0] ra, rb;
        int no_done;
        rst = 1'b0; start = 1'b0; a_in = '0; b_in = '0;
        #3;
        chk("reset mult_control", mc, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("idle busy", busy, 0);

        @(negedge clk); run_op(8'sd3, 8'sd4, 0, "3*4");
        @(negedge clk);
        chk("after done busy", busy, 0);
        chk("after done done", done, 0);

        @(negedge clk); run_op(8'sd0, 8'sd7, 0, "0*7");
        @(negedge clk); run_op(-8'sd5, -8'sd5, 0, "-5*-5");
        @(negedge clk); run_op(8'sd1, 8'sh55, 0, "1*0x55");

        // start held across two back-to-back operations
        @(negedge clk); run_op(-8'sd9, 8'sd3, 1, "held -9*3");
        @(negedge clk);
        chk("held idle busy", busy, 0);
        chk("held idle load_A", mc[4], 0);
        run_op(8'sd6, -8'sd7, 1, "held 6*-7");
        start = 1'b0;
        @(negedge clk);

        // abort during the 4th ITER cycle (cycle 7) of 127*127
        @(negedge clk);
        a_in = 8'sd127; b_in = 8'sd127; start = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
        end
        chk("4th ITER is plain shift", mc, 5'b00010);
        rst = 1'b0;
        #1;
        chk("abort mult_control", mc, 0);
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        no_done = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done) no_done = 1;
        end
        chk("no done during abort", no_done, 0);
        rst = 1'b1;
        @(negedge clk); run_op(8'sd127, 8'sd127, 0, "post-abort 127*127");

        for (int t = 0; t < 25; t++) begin
            ra = N'($signed($urandom_range(254)) - 127);
            rb = N'($urandom);
            @(negedge clk);
            run_op(ra, rb, 0, $sformatf("rand%0d %0d*%0d", t, ra, rb));
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/booth_ctrl.md
BOOTH_CTRL -- requirements
Module: booth_ctrl

Interface
REQ-001 Parameter N SHALL default to 8 and SHALL set the operand width, which is also the Booth iteration count.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  SHALL request one multiplication; sampled only in IDLE.
REQ-005 Q_LSB  input  2  datapath {Q0, Q-1} pair, registered datapath state.
REQ-006 mult_control  output  5  SHALL be packed as {load_A, load_B, load_add, shift_HQ_LQ_Q_1, add_sub}.
REQ-007 busy  output  1  SHALL be high in every state except IDLE.
REQ-008 done  output  1  SHALL be a one-cycle pulse when the product is valid on the datapath Y output.

Function
REQ-009 States SHALL be IDLE, LOAD_A, LOAD_B, ITER, SHIFT, DONE.
REQ-010 IDLE: all outputs SHALL be 0; start=1 SHALL move to LOAD_A, otherwise the FSM SHALL stay in IDLE.
REQ-011 LOAD_A: load_A=1 for one cycle, then the FSM SHALL move to LOAD_B.
REQ-012 LOAD_B: load_B=1 for one cycle; the iteration counter SHALL clear to 0; then the FSM SHALL move to ITER.
REQ-013 ITER with Q_LSB=01: load_add=1 and add_sub=1 (add M); next state SHIFT.
REQ-014 ITER with Q_LSB=10: load_add=1 and add_sub=0 (subtract M); next state SHIFT.
REQ-015 ITER with Q_LSB=00 or 11: shift_HQ_LQ_Q_1=1 in the same cycle and the counter SHALL increment; next state ITER, or DONE if the counter was N-1.
REQ-016 SHIFT: shift_HQ_LQ_Q_1=1 and the counter SHALL increment; next state ITER, or DONE if the counter was N-1.
REQ-017 ITER/SHIFT outputs SHALL be decoded combinationally from the state and Q_LSB (Mealy only in ITER); all other outputs SHALL be Moore.
REQ-018 At most one of load_A, load_B, load_add and shift_HQ_LQ_Q_1 SHALL be high in any cycle.
REQ-019 add_sub SHALL be 0 whenever load_add=0.
REQ-020 DONE: done=1 and busy=1 for exactly one cycle, then the FSM SHALL unconditionally return to IDLE.
REQ-021 start SHALL be ignored while busy=1, and also in DONE; a held start SHALL begin the next operation only from IDLE.
REQ-022 Exactly N shift pulses SHALL occur per operation.
REQ-023 load_add pulses per operation SHALL equal the number of 01/10 pairs seen, between 0 and N.
REQ-024 Latency, counted from the cycle start is sampled, with LOAD_A as cycle 1: DONE SHALL fall in cycle 3+N+k, where k is the number of add/sub operations.
REQ-025 Latency bounds SHALL be: minimum N+3 cycles, maximum 2N+3 cycles.
REQ-026 The counter SHALL be $clog2(N) bits wide, SHALL never wrap within an operation, and SHALL hold its value in IDLE.

Reset
REQ-027 rst=0 SHALL asynchronously force state IDLE, counter 0, mult_control=0, busy=0 and done=0, from any state.
REQ-028 Reset asserted mid-operation SHALL abort the operation without a done pulse.
REQ-029 The first start after reset is released SHALL run a complete, correct sequence.

Structure
REQ-030 Package booth_pkg SHALL hold: the state enum typedef; bit-index constants for the mult_control fields; Q_LSB codes (NOP0=00, ADD=01, SUB=10, NOP1=11).
REQ-031 booth_ctrl SHALL be a single module with no sub-module; counter and FSM are inline.
REQ-032 The verification top SHALL pair booth_ctrl with the existing mult datapath, wired through mult_control and Q_LSB.

Verification
REQ-033 A=3, B=4, start pulse -> k=2; done SHALL fall in cycle 13; Y=12; busy SHALL be high in cycles 1-13.
REQ-034 A=0, B=7 -> k=2; done SHALL fall in cycle 13; Y=0.
REQ-035 A=-5, B=-5 -> k=3; done SHALL fall in cycle 14; Y=25.
REQ-036 A=1, B=0x55 -> k=8 (maximum); done SHALL fall in cycle 19; Y=85; 8 load_add pulses and 8 shift pulses.
REQ-037 start held high across two operations (A=-9, B=3, then A=6, B=-7) -> Y=-27, then Y=-42.
REQ-038 In REQ-037, exactly one load_A pulse SHALL occur per operation, and the second LOAD_A SHALL occur only after an IDLE cycle.
REQ-039 rst=0 asserted during the 4th ITER of A=127, B=127 -> outputs SHALL be 0 immediately with no done.
REQ-040 After the REQ-039 abort, a new start with A=127, B=127 SHALL give Y=16129.
